// File: rtl/biss_c_frame_rx.sv
// BiSS-C master receive stage: samples SLO on each rising edge of the
// delay-compensated MA clock and parses ACK / start / CDS / position / nE / nW /
// CRC6, presenting one registered result per frame.
// Optional feature macro: BISS_RX_CRC_CHECK_EN (CRC6 check; when undefined the
// CRC bits are still consumed and crc_ok reads 1 after every frame).
module biss_c_frame_rx #(
  parameter int POS_BITS    = 26,
  parameter int ACK_TIMEOUT = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                ma_dly,
  input  logic                slo,
  output logic [POS_BITS-1:0] position,
  output logic                err_n,
  output logic                warn_n,
  output logic                crc_ok,
  output logic                frame_valid,
  output logic                timeout_err,
  output logic                busy
);

  localparam int TW  = $clog2(ACK_TIMEOUT + 1);
  localparam int BW0 = $clog2(POS_BITS + 3);
  // The CRC phase reuses the bit counter up to 5, so keep at least 3 bits.
  localparam int BW  = (BW0 < 3) ? 3 : BW0;

  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [BW-1:0] NE_IDX   = BW'(POS_BITS);
  localparam logic [BW-1:0] NW_IDX   = BW'(POS_BITS + 1);
  localparam logic [BW-1:0] CRC_LAST = BW'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_START,
    S_CDS,
    S_DATA,
    S_CRC,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_slo_sync;
  logic                   r_ma_q;
  logic [BW-1:0]          r_bit_cnt;
  logic [BW-1:0]          w_bit_cnt_nxt;
  logic [TW-1:0]          r_to_cnt;
  logic [TW-1:0]          w_to_cnt_nxt;
  logic                   w_timeout;
  logic                   w_done;
  logic                   w_stb;
  logic                   w_bit;
  logic [POS_BITS-1:0]    r_pos_sh;
  logic                   r_ne;
  logic                   r_nw;

`ifdef BISS_RX_CRC_CHECK_EN
  logic [5:0]             r_crc_rx;
  logic [5:0]             r_crc_calc;

  // One serial step of CRC6, polynomial x^6+x+1.
  function automatic logic [5:0] crc6_step(input logic [5:0] c, input logic b);
    logic fb;
    fb = c[5] ^ b;
    return {c[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
  endfunction
`endif

  assign w_bit = r_slo_sync[SYNC_STAGES-1];
  assign w_stb = ma_dly & ~r_ma_q;
  assign busy  = (r_state != S_IDLE);

  // SLO synchronizer and MA edge-detect register (idle-high line).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slo_sync <= '1;
      r_ma_q     <= 1'b1;
    end else begin
      r_slo_sync <= {r_slo_sync[SYNC_STAGES-2:0], slo};
      r_ma_q     <= ma_dly;
    end
  end

  // FSM state and frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
    end
  end

  // Next-state logic; everything except IDLE/DONE moves only on a sample strobe.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_timeout     = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_state_nxt   = S_ACK;
          w_bit_cnt_nxt = '0;
          w_to_cnt_nxt  = '0;
        end
      end
      S_ACK, S_START: begin
        if (w_stb) begin
          if ((r_state == S_ACK) && !w_bit) begin
            w_state_nxt = S_START;
          end else if ((r_state == S_START) && w_bit) begin
            w_state_nxt = S_CDS;
          end else if (r_to_cnt == TO_LAST) begin
            w_state_nxt = S_IDLE;
            w_timeout   = 1'b1;
          end else begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
          end
        end
      end
      S_CDS: begin
        if (w_stb) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_stb) begin
          if (r_bit_cnt == NW_IDX) begin
            w_state_nxt   = S_CRC;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_CRC: begin
        if (w_stb) begin
          if (r_bit_cnt == CRC_LAST) w_state_nxt = S_DONE;
          else                       w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Receive shift registers (datapath, no reset; CRC seeded during CDS).
  always_ff @(posedge clk) begin
    if ((r_state == S_DATA) && w_stb) begin
      if (r_bit_cnt < NE_IDX)       r_pos_sh <= (r_pos_sh << 1) | POS_BITS'(w_bit);
      else if (r_bit_cnt == NE_IDX) r_ne     <= w_bit;
      else                          r_nw     <= w_bit;
    end
`ifdef BISS_RX_CRC_CHECK_EN
    if (r_state == S_CDS)                  r_crc_calc <= '0;
    else if ((r_state == S_DATA) && w_stb) r_crc_calc <= crc6_step(r_crc_calc, w_bit);
    if ((r_state == S_CRC) && w_stb)       r_crc_rx   <= {r_crc_rx[4:0], w_bit};
`endif
  end

  // Result registers: updated once per frame in DONE, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      position    <= '0;
      err_n       <= 1'b1;
      warn_n      <= 1'b1;
      crc_ok      <= 1'b0;
      frame_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_valid <= w_done;
      timeout_err <= w_timeout;
      if (w_done) begin
        position <= r_pos_sh;
        err_n    <= r_ne;
        warn_n   <= r_nw;
`ifdef BISS_RX_CRC_CHECK_EN
        crc_ok   <= (~r_crc_rx == r_crc_calc);
`else
        crc_ok   <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_biss_c_frame_rx.sv
// Directed bench for biss_c_frame_rx (default parameters, POS_BITS=26).
module tb_biss_c_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        ma_dly = 1'b0;
  logic        slo = 1'b1;
  logic [25:0] position;
  logic        err_n, warn_n, crc_ok, frame_valid, timeout_err, busy;

  int n_vec = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int to_cnt = 0;

`ifdef BISS_RX_CRC_CHECK_EN
  localparam logic BAD_CRC_EXP = 1'b0;
`else
  localparam logic BAD_CRC_EXP = 1'b1;
`endif

  typedef struct {
    logic [25:0] pos;
    logic        ne;
    logic        nw;
    logic [5:0]  flip;
    int          fs_bit;
    logic        fs_done;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[5];

  biss_c_frame_rx dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .ma_dly      (ma_dly),
    .slo         (slo),
    .position    (position),
    .err_n       (err_n),
    .warn_n      (warn_n),
    .crc_ok      (crc_ok),
    .frame_valid (frame_valid),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters.
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (timeout_err) to_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC6 (x^6+x+1, seed 0) by polynomial long division of message * x^6.
  function automatic logic [5:0] crc_model(input logic [25:0] p, input logic ne, input logic nw);
    logic [33:0] m;
    m = {p, ne, nw, 6'b0};
    for (int i = 33; i >= 6; i--)
      if (m[i]) m[i -: 7] = m[i -: 7] ^ 7'h43;
    return m[5:0];
  endfunction

  // One SLO bit: set line, let it synchronize, then raise ma_dly (strobe).
  task automatic send_bit(input logic b, input logic fs);
    @(negedge clk); slo = b; ma_dly = 1'b0; frame_start = fs;
    @(negedge clk); frame_start = 1'b0;
    repeat (2) @(negedge clk);
    ma_dly = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic preamble();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);  // ACK
    send_bit(1'b1, 1'b0);  // start
    send_bit(1'b0, 1'b0);  // CDS
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [5:0] tx;
    int         fv0;
    fv0 = fv_cnt;
    pulse_start();
    preamble();
    for (int i = 0; i < 26; i++) send_bit(v.pos[25-i], (i == v.fs_bit));
    send_bit(v.ne, 1'b0);
    send_bit(v.nw, 1'b0);
    tx = ~crc_model(v.pos, v.ne, v.nw) ^ v.flip;
    for (int i = 5; i >= 0; i--) send_bit(tx[i], 1'b0);
    @(negedge clk);  // DONE cycle
    chk({tag, ".fv_early"}, {31'd0, frame_valid}, 32'd0);
    frame_start = v.fs_done;
    @(negedge clk);
    frame_start = 1'b0;
    chk({tag, ".fv_latency"}, {31'd0, frame_valid}, 32'd1);
    chk({tag, ".position"}, {6'd0, position}, {6'd0, v.pos});
    chk({tag, ".err_n"}, {31'd0, err_n}, {31'd0, v.ne});
    chk({tag, ".warn_n"}, {31'd0, warn_n}, {31'd0, v.nw});
    chk({tag, ".crc_ok"}, {31'd0, crc_ok}, {31'd0, v.exp_ok});
    repeat (3) @(negedge clk);
    chk({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, ".fv_count"}, fv_cnt - fv0, 32'd1);
  endtask

  initial begin
    vecs[0] = '{pos: 26'h2AAAAAA, ne: 1'b1, nw: 1'b1, flip: 6'h00, fs_bit: -1, fs_done: 1'b0, exp_ok: 1'b1};
    vecs[1] = '{pos: 26'h2AAAAAA, ne: 1'b1, nw: 1'b1, flip: 6'h08, fs_bit: -1, fs_done: 1'b0, exp_ok: BAD_CRC_EXP};
    vecs[2] = '{pos: 26'h0000001, ne: 1'b0, nw: 1'b0, flip: 6'h00, fs_bit: -1, fs_done: 1'b0, exp_ok: 1'b1};
    vecs[3] = '{pos: 26'h1234567, ne: 1'b1, nw: 1'b0, flip: 6'h00, fs_bit: 5,  fs_done: 1'b1, exp_ok: 1'b1};
    vecs[4] = '{pos: 26'h0ABCDEF, ne: 1'b0, nw: 1'b1, flip: 6'h00, fs_bit: -1, fs_done: 1'b0, exp_ok: 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.position", {6'd0, position}, 32'd0);
    chk("reset.err_n", {31'd0, err_n}, 32'd1);
    chk("reset.warn_n", {31'd0, warn_n}, 32'd1);
    chk("reset.crc_ok", {31'd0, crc_ok}, 32'd0);
    chk("reset.frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("reset.timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 5; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

    // ACK timeout: SLO stays high for ACK_TIMEOUT strobes.
    begin
      int fv0, to0;
      fv0 = fv_cnt;
      to0 = to_cnt;
      pulse_start();
      for (int i = 0; i < 31; i++) send_bit(1'b1, 1'b0);
      @(negedge clk);
      chk("tmo.busy_at31", {31'd0, busy}, 32'd1);
      chk("tmo.no_pulse_at31", to_cnt - to0, 32'd0);
      send_bit(1'b1, 1'b0);
      @(negedge clk);
      chk("tmo.pulse", {31'd0, timeout_err}, 32'd1);
      chk("tmo.busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("tmo.count", to_cnt - to0, 32'd1);
      chk("tmo.no_fv", fv_cnt - fv0, 32'd0);
      chk("tmo.position_held", {6'd0, position}, 32'h00ABCDEF);
      chk("tmo.err_n_held", {31'd0, err_n}, 32'd0);
      chk("tmo.warn_n_held", {31'd0, warn_n}, 32'd1);
      chk("tmo.crc_ok_held", {31'd0, crc_ok}, 32'd1);
    end

    // Reset in the middle of DATA (bit 10), then a clean frame.
    begin
      logic [25:0] p;
      int          fv0;
      p = 26'h1555555;
      fv0 = fv_cnt;
      pulse_start();
      preamble();
      for (int i = 0; i < 10; i++) send_bit(p[25-i], 1'b0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("rstmid.position", {6'd0, position}, 32'd0);
      chk("rstmid.err_n", {31'd0, err_n}, 32'd1);
      chk("rstmid.warn_n", {31'd0, warn_n}, 32'd1);
      chk("rstmid.crc_ok", {31'd0, crc_ok}, 32'd0);
      chk("rstmid.busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("rstmid.no_fv", fv_cnt - fv0, 32'd0);
      chk("rstmid.timeout_err", {31'd0, timeout_err}, 32'd0);
      run_frame('{pos: 26'h3FFFFFF, ne: 1'b1, nw: 1'b1, flip: 6'h00, fs_bit: -1, fs_done: 1'b0, exp_ok: 1'b1},
                "after_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/biss_c_frame_rx.md
Name: biss_c_frame_rx

Overview:
- Receive stage of the BiSS-C master; sits directly downstream of the MA-clock delay line.
- Samples encoder SLO on rising edges of the line-delay-compensated MA clock level (`ma_dly`).
- Parses ACK / start / CDS / position / nE / nW / CRC6 and presents one result per frame with status flags.

Parameters:
- POS_BITS, 26, position field width in bits (1..32).
- ACK_TIMEOUT, 32, maximum sample edges allowed in ACK and START hunting before abort (>=2).
- SYNC_STAGES, 2, synchronizer depth on `slo` (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse from the MA generator when a frame begins
- ma_dly  in  1  delayed MA clock level; each rising edge is one sample point
- slo  in  1  encoder SLO line, asynchronous
- position  out  POS_BITS  last accepted position, MSB-first assembled
- err_n  out  1  received nE bit (active-low error)
- warn_n  out  1  received nW bit (active-low warning)
- crc_ok  out  1  CRC6 of last frame matched
- frame_valid  out  1  one-cycle pulse when a frame completes
- timeout_err  out  1  one-cycle pulse when ACK/START hunting exceeds ACK_TIMEOUT
- busy  out  1  high from accepted `frame_start` until DONE/abort

Behaviour:
- Reset:
  - position=0, err_n=1, warn_n=1, crc_ok=0, frame_valid=0, timeout_err=0, busy=0.
  - State IDLE; synchronizer flops=1; ma_dly edge register=1.
  - A reset mid-frame aborts immediately with no valid/timeout pulse.
- Input conditioning:
  - `slo` passes through a SYNC_STAGES flop chain.
  - Sample strobe = `ma_dly` & ~`ma_dly` registered (one clk later).
  - The sampled bit is the synchronized `slo` in the strobe cycle.
- FSM (advances only on strobe, except where noted):
  - IDLE: on `frame_start` -> ACK, busy=1, clear bit counter and timeout counter.
  - ACK: sample 0 -> START; else increment timeout counter; reaching ACK_TIMEOUT -> IDLE with timeout_err pulse.
  - START: sample 1 -> CDS; else same timeout rule, counter continues from ACK.
  - CDS: consume one bit, discard -> DATA.
  - DATA: shift POS_BITS bits MSB-first, then the nE bit, then the nW bit -> CRC.
  - CRC: shift 6 bits MSB-first -> DONE.
  - DONE (no strobe needed, 1 cycle): update position, err_n, warn_n, crc_ok; pulse frame_valid; busy=0 -> IDLE.
- Outputs hold their values between frames.
- CRC6:
  - Polynomial x^6+x+1 (0x43), seed 0.
  - Computed serially over position, nE and nW bits, in received order.
  - Transmitted CRC is inverted; crc_ok = (~rx_crc == computed).
- `frame_start` while busy is ignored.
- `frame_start` in the same cycle as DONE is ignored (state is DONE, not IDLE).
- A strobe in the same cycle as `frame_start` is not counted; the first counted strobe is the next one.
- Timeout counter width = clog2(ACK_TIMEOUT+1).
- Bit counter width = clog2(POS_BITS+3); it wraps to 0 on entering CRC.
- Latency: frame_valid asserts 2 clk after the strobe that samples the last CRC bit (one cycle into DONE, one registered).

Optional Feature:
- Macro: BISS_RX_CRC_CHECK_EN.
- Defined: CRC6 computed and compared as above.
- Undefined:
  - CRC logic removed; the 6 CRC bits are still consumed so framing is unchanged.
  - crc_ok is driven 1 on every DONE.
  - Reset value of crc_ok stays 0.

Test Plan:
- Nominal frame, POS_BITS=26: ACK after 3 strobes, position=0x2AAAAAA, nE=1, nW=1, CRC from bench model -> single frame_valid; position=0x2AAAAAA, err_n=1, warn_n=1, crc_ok=1, busy low after.
- Same frame with CRC bit 3 flipped -> frame_valid pulses, crc_ok=0, position still 0x2AAAAAA. With BISS_RX_CRC_CHECK_EN undefined -> crc_ok=1.
- SLO held high after frame_start, ACK_TIMEOUT=32 -> timeout_err pulse after the 32nd strobe, no frame_valid, busy=0, outputs unchanged.
- nE=0, nW=0, position=0x0000001 -> err_n=0, warn_n=0, position=0x0000001, crc_ok=1.
- Assert rst mid-DATA (bit 10) -> all outputs at reset values next cycle. A new frame_start then decodes position=0x3FFFFFF correctly.
- frame_start re-pulsed during DATA and in the DONE cycle -> ignored; exactly one frame_valid; the following frame decodes normally.
